slink_link_framer: RTL

Link-layer framer/deframer for the serial link, generalising the fixed all-channel split into a runtime channel mask. Channels can be disabled during calibration or after a lane fault, and traffic continues in degraded mode over the remaining channels. It sits between the AXI-stream payload side and the per-channel PHY FIFOs. On transmit it slices each payload into beats across the active channels. On receive it reassembles beats into payloads.

---
 rtl/slink_link_framer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/slink_link_framer.sv
// slink_link_framer: link-layer framer/deframer with a runtime channel mask.
// TX slices a payload into beats across the active channels. RX reassembles
// received beats into a payload.
// Optional feature macro: SLINK_FRAMER_STATS_EN (saturating payload counters).
// PayloadW is assumed to be a whole multiple of ChanW.
module slink_link_framer #(
    parameter int PayloadW    = 256,
    parameter int NumChannels = 4,
    parameter int ChanW       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [PayloadW-1:0]          tx_data_i,
    input  logic                         tx_valid_i,
    output logic                         tx_ready_o,
    output logic [NumChannels*ChanW-1:0] data_out_o,
    output logic [NumChannels-1:0]       data_out_valid_o,
    input  logic                         data_out_ready_i,
    input  logic [NumChannels*ChanW-1:0] data_in_i,
    input  logic [NumChannels-1:0]       data_in_valid_i,
    output logic [NumChannels-1:0]       data_in_ready_o,
    output logic [PayloadW-1:0]          rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    input  logic [NumChannels-1:0]       cfg_ch_mask_i,
    output logic [NumChannels-1:0]       cur_ch_mask_o,
    output logic                         tx_busy_o,
    output logic                         rx_busy_o,
    output logic [31:0]                  stat_tx_cnt_o,
    output logic [31:0]                  stat_rx_cnt_o
);

    localparam int NumChunks = PayloadW / ChanW;
    localparam int ChkW      = $clog2(NumChunks);
    localparam int IdxW      = $clog2(NumChunks) + 1;
    localparam int NW        = $clog2(NumChannels + 1);
    localparam int CIW       = IdxW + NW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [NumChannels-1:0] cur_mask_q;
    logic [0:0]             state_reg, state_next;
    logic [IdxW-1:0]        tx_idx_reg, tx_idx_next;
    logic [IdxW-1:0]        rx_idx_reg;
    logic                   rx_held_reg;
    logic [ChanW-1:0]       rx_acc_reg [NumChunks];

    logic [ChanW-1:0]       tx_chunks  [NumChunks];
    logic [NW-1:0]          ch_rank    [NumChannels];
    logic [CIW-1:0]         tx_cidx    [NumChannels];
    logic [CIW-1:0]         rx_cidx    [NumChannels];
    logic [IdxW-1:0]        beats_lut  [NumChannels+1];

    logic [NW-1:0]          n_act;
    logic [IdxW-1:0]        beats_n;
    logic [IdxW-1:0]        tx_cur_idx;
    logic                   tx_present, tx_fire, tx_last;
    logic                   rx_all_valid, rx_accept, rx_last;
    logic                   mask_load;

    // Beats per payload for every possible active-channel count (entry 0 unused)
    generate
        for (genvar gi = 0; gi <= NumChannels; gi++) begin : g_beats
            if (gi == 0) begin : g_zero
                assign beats_lut[gi] = IdxW'(1);
            end else begin : g_nz
                assign beats_lut[gi] = IdxW'((PayloadW + gi*ChanW - 1) / (gi*ChanW));
            end
        end
    endgenerate

    assign n_act   = NW'($countones(cur_mask_q));
    assign beats_n = beats_lut[n_act];

    // Rank of each channel among the active ones picks which chunk it carries
    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_rank
            if (gi == 0) begin : g_first
                assign ch_rank[gi] = '0;
            end else begin : g_rest
                assign ch_rank[gi] = NW'($countones(cur_mask_q[gi-1:0]));
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NumChunks; gi++) begin : g_chunks
            assign tx_chunks[gi]                = tx_data_i[gi*ChanW +: ChanW];
            assign rx_data_o[gi*ChanW +: ChanW] = rx_acc_reg[gi];
        end
    endgenerate

    // ---------------- TX path ----------------
    assign tx_present = rst_ni && ((state_reg == ST_SEND) || tx_valid_i);
    assign tx_cur_idx = (state_reg == ST_SEND) ? tx_idx_reg : '0;
    assign tx_last    = (tx_cur_idx == beats_n - IdxW'(1));
    assign tx_fire    = tx_present && data_out_ready_i;
    assign tx_ready_o = tx_fire && tx_last;
    assign tx_busy_o  = (state_reg == ST_SEND);

    // Per-channel beat slicing; chunks past the payload end read as zero
    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_tx_chan
            assign tx_cidx[gi] = CIW'(tx_cur_idx) * CIW'(n_act) + CIW'(ch_rank[gi]);
            assign data_out_valid_o[gi] = tx_present && cur_mask_q[gi];
            assign data_out_o[gi*ChanW +: ChanW] =
                (tx_present && cur_mask_q[gi] && (tx_cidx[gi] < CIW'(NumChunks)))
                    ? tx_chunks[tx_cidx[gi][ChkW-1:0]] : '0;
        end
    endgenerate

    // TX sequencing: Idle presents beat 0, Send walks the remaining beats
    always_comb begin
        state_next  = state_reg;
        tx_idx_next = tx_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tx_fire && !tx_last) begin
                    state_next  = ST_SEND;
                    tx_idx_next = IdxW'(1);
                end
            end
            default: begin
                if (tx_fire) begin
                    if (tx_last) begin
                        state_next  = ST_IDLE;
                        tx_idx_next = '0;
                    end else begin
                        tx_idx_next = tx_idx_reg + IdxW'(1);
                    end
                end
            end
        endcase
    end

    // TX state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            tx_idx_reg <= '0;
        end else begin
            state_reg  <= state_next;
            tx_idx_reg <= tx_idx_next;
        end
    end

    // ---------------- RX path ----------------
    assign rx_all_valid    = ((data_in_valid_i & cur_mask_q) == cur_mask_q);
    assign rx_accept       = rst_ni && rx_all_valid && (!rx_held_reg || rx_ready_i);
    assign rx_last         = (rx_idx_reg == beats_n - IdxW'(1));
    assign data_in_ready_o = rx_accept ? cur_mask_q : '0;
    assign rx_valid_o      = rx_held_reg;
    assign rx_busy_o       = (rx_idx_reg != '0);

    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_rx_chan
            assign rx_cidx[gi] = CIW'(rx_idx_reg) * CIW'(n_act) + CIW'(ch_rank[gi]);
        end
    endgenerate

    // RX beat index and completed-payload flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_idx_reg  <= '0;
            rx_held_reg <= 1'b0;
        end else begin
            if (rx_accept) begin
                rx_idx_reg <= rx_last ? '0 : rx_idx_reg + IdxW'(1);
            end
            if (rx_accept && rx_last) begin
                rx_held_reg <= 1'b1;
            end else if (rx_ready_i) begin
                rx_held_reg <= 1'b0;
            end
        end
    end

    // Accumulator: each accepted chunk lands at its payload position
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int t = 0; t < NumChunks; t++) begin
                rx_acc_reg[t] <= '0;
            end
        end else if (rx_accept) begin
            for (int c = 0; c < NumChannels; c++) begin
                if (cur_mask_q[c] && (rx_cidx[c] < CIW'(NumChunks))) begin
                    rx_acc_reg[rx_cidx[c][ChkW-1:0]] <= data_in_i[c*ChanW +: ChanW];
                end
            end
        end
    end

    // ---------------- Channel mask ----------------
    // A new mask is taken only when neither direction has a payload in flight
    // after this edge, so a payload is never split across two masks.
    assign mask_load = (state_reg == ST_IDLE) && !(tx_fire && !tx_last) &&
                       (rx_idx_reg == '0) && !rx_held_reg &&
                       !(rx_accept && !rx_last) && (cfg_ch_mask_i != '0);

    // Effective channel mask
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cur_mask_q <= '1;
        end else if (mask_load) begin
            cur_mask_q <= cfg_ch_mask_i;
        end
    end

    assign cur_ch_mask_o = cur_mask_q;

    // ---------------- Statistics ----------------
`ifdef SLINK_FRAMER_STATS_EN
    logic [31:0] stat_tx_reg;
    logic [31:0] stat_rx_reg;

    // Saturating counts of completed TX and RX payload handshakes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_tx_reg <= '0;
            stat_rx_reg <= '0;
        end else begin
            if (tx_ready_o && (stat_tx_reg != '1)) begin
                stat_tx_reg <= stat_tx_reg + 32'd1;
            end
            if (rx_valid_o && rx_ready_i && (stat_rx_reg != '1)) begin
                stat_rx_reg <= stat_rx_reg + 32'd1;
            end
        end
    end

    assign stat_tx_cnt_o = stat_tx_reg;
    assign stat_rx_cnt_o = stat_rx_reg;
`else
    assign stat_tx_cnt_o = '0;
    assign stat_rx_cnt_o = '0;
`endif

endmodule
